viterbi_feed_ctrl: RTL and testbench

Frame-level sequencer in front of the 802.11a receiver Viterbi decoder. It accepts the deinterleaved coded bit stream one bit at a time and depunctures it for rate 1/2, 2/3 or 3/4. It issues one (A,B) soft-erasure symbol per decoder step, then counts decoded bits until the frame is complete. It owns frame start/stop, rate selection and back-pressure for the decoder datapath.

---
 rtl/viterbi_feed_ctrl_if.sv | 36 +++
 rtl/viterbi_feed_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_viterbi_feed_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_feed_ctrl_if.sv
// rtl/viterbi_feed_ctrl_if.sv - coded-bit input stream and decoder symbol stream for viterbi_feed_ctrl
interface viterbi_feed_ctrl_if;
    // coded bit stream from the deinterleaver
    logic       in_tdata;
    logic       in_tvalid;
    logic       in_tready;
    // soft-erasure symbol towards the Viterbi decoder, [1]=A, [0]=B
    logic [1:0] dec_tdata;
    logic [1:0] dec_erase;
    logic       dec_tvalid;
    logic       dec_tready;
    // one pulse per decoded bit emitted by the decoder
    logic       dec_out_valid;

    modport master (
        output in_tdata,
        output in_tvalid,
        input  in_tready,
        input  dec_tdata,
        input  dec_erase,
        input  dec_tvalid,
        output dec_tready,
        output dec_out_valid
    );

    modport slave (
        input  in_tdata,
        input  in_tvalid,
        output in_tready,
        output dec_tdata,
        output dec_erase,
        output dec_tvalid,
        input  dec_tready,
        input  dec_out_valid
    );
endinterface

// File: rtl/viterbi_feed_ctrl.sv
// rtl/viterbi_feed_ctrl.sv - depuncturing frame sequencer in front of the 802.11a Viterbi decoder
module viterbi_feed_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       rate_sel_i,
    input  logic [CNT_W-1:0] num_symbols_i,
    input  logic             abort_i,
    viterbi_feed_ctrl_if.slave bus,
    output logic [CNT_W-1:0] out_count_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_ISSUE   = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    // rate_q doubles as the index of the last puncture phase (0: 1/2, 1: 2/3, 2: 3/4)
    logic [1:0]       rate_q, rate_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [1:0]       phase_q, phase_d;
    logic             second_q, second_d;
    logic             sym_a_q, sym_a_d;
    logic             sym_b_q, sym_b_d;
    logic [1:0]       erase_q, erase_d;
    logic [CNT_W-1:0] symcnt_q, symcnt_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             start_ok;
    logic             accept;
    logic             phase_last;
    logic             issue_fire;
    logic             last_sym;

    assign start_ok   = (state_q == S_IDLE) && start_i && !abort_i;
    assign accept     = (state_q == S_COLLECT) && bus.in_tvalid && !abort_i;
    // phase 0 carries two coded bits, every other phase a single bit
    assign phase_last = (phase_q != 2'd0) || second_q;
    assign issue_fire = (state_q == S_ISSUE) && bus.dec_tready && !abort_i;
    assign last_sym   = (symcnt_q + CNT_W'(1)) == num_q;

    // datapath next-state: frame latch, depuncture capture, symbol and output counters
    always_comb begin
        rate_d      = rate_q;
        num_d       = num_q;
        phase_d     = phase_q;
        second_d    = second_q;
        sym_a_d     = sym_a_q;
        sym_b_d     = sym_b_q;
        erase_d     = erase_q;
        symcnt_d    = symcnt_q;
        out_count_d = out_count_q;
        if (start_ok) begin
            rate_d      = (rate_sel_i == 2'd3) ? 2'd0 : rate_sel_i;
            num_d       = num_symbols_i;
            phase_d     = 2'd0;
            second_d    = 1'b0;
            symcnt_d    = '0;
            out_count_d = '0;
        end else begin
            if (accept) begin
                case (phase_q)
                    2'd0: begin
                        if (!second_q) begin
                            sym_a_d  = bus.in_tdata;
                            second_d = 1'b1;
                        end else begin
                            sym_b_d  = bus.in_tdata;
                            second_d = 1'b0;
                            erase_d  = 2'b00;
                        end
                    end
                    2'd1: begin
                        sym_a_d = bus.in_tdata;
                        sym_b_d = 1'b0;
                        erase_d = 2'b01;
                    end
                    default: begin
                        sym_a_d = 1'b0;
                        sym_b_d = bus.in_tdata;
                        erase_d = 2'b10;
                    end
                endcase
            end
            if (issue_fire) begin
                symcnt_d = symcnt_q + CNT_W'(1);
                phase_d  = (phase_q == rate_q) ? 2'd0 : phase_q + 2'd1;
            end
            // saturating decoded-bit count; an aborted frame keeps its count
            if ((state_q != S_IDLE) && !abort_i && bus.dec_out_valid && (out_count_q != num_q)) begin
                out_count_d = out_count_q + CNT_W'(1);
            end
        end
    end

    // datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rate_q      <= 2'd0;
            num_q       <= '0;
            phase_q     <= 2'd0;
            second_q    <= 1'b0;
            sym_a_q     <= 1'b0;
            sym_b_q     <= 1'b0;
            erase_q     <= 2'b00;
            symcnt_q    <= '0;
            out_count_q <= '0;
        end else begin
            rate_q      <= rate_d;
            num_q       <= num_d;
            phase_q     <= phase_d;
            second_q    <= second_d;
            sym_a_q     <= sym_a_d;
            sym_b_q     <= sym_b_d;
            erase_q     <= erase_d;
            symcnt_q    <= symcnt_d;
            out_count_q <= out_count_d;
        end
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = (num_symbols_i == '0) ? S_DONE : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (accept && phase_last) begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.dec_tready) begin
                        state_d = last_sym ? S_DRAIN : S_COLLECT;
                    end
                end
                S_DRAIN: begin
                    // look at the next count so Done follows the final decoded bit by one cycle
                    if (out_count_d == num_q) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // outputs decoded from state and registered symbol; nothing passes straight through from inputs
    always_comb begin
        bus.in_tready  = (state_q == S_COLLECT);
        bus.dec_tvalid = (state_q == S_ISSUE);
        bus.dec_tdata  = (state_q == S_ISSUE) ? {sym_a_q, sym_b_q} : 2'b00;
        bus.dec_erase  = (state_q == S_ISSUE) ? erase_q : 2'b00;
        busy_o         = (state_q != S_IDLE);
        done_o         = (state_q == S_DONE);
        out_count_o    = out_count_q;
    end

endmodule

// File: tb/tb_viterbi_feed_ctrl.sv
// tb/tb_viterbi_feed_ctrl.sv - directed scoreboard bench for viterbi_feed_ctrl
module tb_viterbi_feed_ctrl;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start;
    logic [1:0]       rate_sel;
    logic [CNT_W-1:0] num;
    logic             abort;
    logic [CNT_W-1:0] out_count;
    logic             busy;
    logic             done;

    viterbi_feed_ctrl_if vif ();

    viterbi_feed_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .rate_sel_i    (rate_sel),
        .num_symbols_i (num),
        .abort_i       (abort),
        .bus           (vif.slave),
        .out_count_o   (out_count),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         done_cnt = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(output bit acc);
        logic [3:0] e;
        @(negedge clk);
        acc = vif.in_tvalid && vif.in_tready;
        if (done) done_cnt++;
        if (vif.dec_tvalid) begin
            check("ready_in_issue", 32'(vif.in_tready), 0);
            if (vif.dec_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_symbol", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("symbol", 32'({vif.dec_tdata, vif.dec_erase}), 32'(e));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        bit a;
        tick(a);
    endtask

    task automatic start_frame(input logic [1:0] r, input logic [CNT_W-1:0] n);
        start = 1'b1;
        rate_sel = r;
        num = n;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int nbits, input logic [7:0] bits, output int cycles);
        int idx;
        bit acc;
        idx = 0;
        cycles = 0;
        while (idx < nbits && cycles < 100) begin
            vif.in_tvalid = 1'b1;
            vif.in_tdata = bits[nbits-1-idx];
            tick(acc);
            cycles++;
            if (acc) idx++;
        end
        vif.in_tvalid = 1'b0;
        check("feed_complete", 32'(idx), 32'(nbits));
    endtask

    task automatic pulses(input int k);
        for (int i = 0; i < k; i++) begin
            vif.dec_out_valid = 1'b1;
            step();
            vif.dec_out_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(vif.in_tready), 0);
        check({tag, "_dec_in"}, 32'(vif.dec_tdata), 0);
        check({tag, "_dec_erase"}, 32'(vif.dec_erase), 0);
        check({tag, "_dec_valid"}, 32'(vif.dec_tvalid), 0);
        check({tag, "_out_count"}, 32'(out_count), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        int  cyc;
        int  d0;
        bit  acc;
        start = 1'b0;
        rate_sel = 2'd0;
        num = '0;
        abort = 1'b0;
        vif.in_tdata = 1'b0;
        vif.in_tvalid = 1'b0;
        vif.dec_tready = 1'b1;
        vif.dec_out_valid = 1'b0;

        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // rate 1/2, four symbols, decoder always ready
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1000);
        start_frame(2'd0, 16'd4);
        check("t1_start_in_ready", 32'(vif.in_tready), 1);
        check("t1_start_busy", 32'(busy), 1);
        feed(8, 8'b11010010, cyc);
        check("t1_last_accept_cycle", 32'(cyc), 11);
        step();
        check("t1_drain_valid", 32'(vif.dec_tvalid), 0);
        check("t1_drain_in_ready", 32'(vif.in_tready), 0);
        check("t1_drain_busy", 32'(busy), 1);
        check("t1_sb_empty", 32'(exp_q.size()), 0);
        d0 = done_cnt;
        pulses(4);
        check("t1_done", 32'(done), 1);
        check("t1_out_count", 32'(out_count), 4);
        step();
        check("t1_done_drop", 32'(done), 0);
        check("t1_idle", 32'(busy), 0);
        check("t1_done_pulses", 32'(done_cnt - d0), 1);

        // rate 3/4, three symbols covering all three phases
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b1001);
        exp_q.push_back(4'b0110);
        start_frame(2'd2, 16'd3);
        feed(4, 8'b00001011, cyc);
        check("t2_last_accept_cycle", 32'(cyc), 6);
        step();
        check("t2_drain_valid", 32'(vif.dec_tvalid), 0);
        check("t2_drain_in_ready", 32'(vif.in_tready), 0);
        check("t2_drain_busy", 32'(busy), 1);
        pulses(3);
        check("t2_done", 32'(done), 1);
        step();
        check("t2_idle", 32'(busy), 0);

        // rate 2/3, decoder stalls three cycles on the first symbol
        vif.dec_tready = 1'b0;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1001);
        start_frame(2'd1, 16'd2);
        feed(2, 8'b00000001, cyc);
        vif.in_tvalid = 1'b1;
        vif.in_tdata = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            check("t3_stall_no_accept", 32'(acc), 0);
            check("t3_stall_valid", 32'(vif.dec_tvalid), 1);
            check("t3_stall_symbol", 32'({vif.dec_tdata, vif.dec_erase}), 32'h4);
        end
        vif.dec_tready = 1'b1;
        tick(acc);
        check("t3_release_no_accept", 32'(acc), 0);
        check("t3_sb_after_release", 32'(exp_q.size()), 1);
        feed(1, 8'b00000001, cyc);
        step();
        check("t3_sb_empty", 32'(exp_q.size()), 0);
        pulses(2);
        check("t3_done", 32'(done), 1);
        step();
        check("t3_idle", 32'(busy), 0);

        // empty frame, then a Start while still busy
        start_frame(2'd0, 16'd0);
        check("t4_done", 32'(done), 1);
        check("t4_in_ready", 32'(vif.in_tready), 0);
        check("t4_busy", 32'(busy), 1);
        start = 1'b1;
        num = 16'd5;
        step();
        start = 1'b0;
        check("t4_done_drop", 32'(done), 0);
        check("t4_idle", 32'(busy), 0);
        step();
        check("t4_start_ignored", 32'(busy), 0);
        check("t4_start_ignored_ready", 32'(vif.in_tready), 0);

        // extra decoded-bit pulses saturate the count
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0000);
        start_frame(2'd0, 16'd4);
        feed(8, 8'b01101100, cyc);
        step();
        d0 = done_cnt;
        pulses(5);
        check("t5_out_count_sat", 32'(out_count), 4);
        check("t5_done_pulses", 32'(done_cnt - d0), 1);
        check("t5_idle", 32'(busy), 0);

        // abort mid-collect, with an ignored Start beforehand
        start_frame(2'd0, 16'd3);
        feed(1, 8'b00000001, cyc);
        start = 1'b1;
        num = 16'd0;
        vif.dec_out_valid = 1'b1;
        step();
        start = 1'b0;
        vif.dec_out_valid = 1'b0;
        check("t6_still_collect", 32'(vif.in_tready), 1);
        check("t6_busy", 32'(busy), 1);
        check("t6_out_count", 32'(out_count), 1);
        d0 = done_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t6_abort_idle", 32'(busy), 0);
        check("t6_abort_in_ready", 32'(vif.in_tready), 0);
        check("t6_abort_count_hold", 32'(out_count), 1);
        step();
        check("t6_no_done", 32'(done_cnt - d0), 0);

        // asynchronous reset while a symbol is being issued
        vif.dec_tready = 1'b0;
        start_frame(2'd0, 16'd2);
        feed(2, 8'b00000011, cyc);
        check("t7_issue_valid", 32'(vif.dec_tvalid), 1);
        check("t7_issue_symbol", 32'({vif.dec_tdata, vif.dec_erase}), 32'hC);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t7_async");
        #2;
        rst_n = 1'b1;
        vif.dec_tready = 1'b1;
        step();
        check("t7_after_reset_idle", 32'(busy), 0);
        check("final_sb_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
